// File: rtl/rtc_core_if.sv
// rtc_core_if: control, load, alarm and time signals of the real-time clock core.
`timescale 1ns/1ps
interface rtc_core_if #(parameter int TS_WIDTH = 32);
   logic                run;
   logic                set_valid;
   logic [4:0]          set_hour;
   logic [5:0]          set_min;
   logic [5:0]          set_sec;
   logic                alarm_en;
   logic [4:0]          alarm_hour;
   logic [5:0]          alarm_min;
   logic [5:0]          alarm_sec;
   logic [4:0]          hour;
   logic [5:0]          min;
   logic [5:0]          sec;
   logic [TS_WIDTH-1:0] timestamp;
   logic                tick;
   logic                day_wrap;
   logic                alarm;
   logic                set_err;
   modport master(output run, set_valid, set_hour, set_min, set_sec, alarm_en, alarm_hour, alarm_min, alarm_sec,
                  input hour, min, sec, timestamp, tick, day_wrap, alarm, set_err);
   modport slave(input run, set_valid, set_hour, set_min, set_sec, alarm_en, alarm_hour, alarm_min, alarm_sec,
                 output hour, min, sec, timestamp, tick, day_wrap, alarm, set_err);
endinterface

// File: rtl/rtc_core.sv
// rtc_core: prescaled 1 Hz real-time clock with load, pause, uptime timestamp and one-shot alarm.
`timescale 1ns/1ps
module rtc_core #(
   parameter int CLK_HZ   = 125_000_000,
   parameter int TS_WIDTH = 32
) (
   input logic       clk,
   input logic       rst_n,
   rtc_core_if.slave b
);
   localparam int PW = $clog2(CLK_HZ);
   logic [PW-1:0] pre;
   logic          ok, ld, tc, adv, wrap_m, dw;
   logic [5:0]    ns, nm;
   logic [4:0]    nh;
   always_comb begin
      ok     = b.set_hour <= 5'd23 && b.set_min <= 6'd59 && b.set_sec <= 6'd59;
      ld     = b.set_valid && ok;
      tc     = b.run && pre == PW'(CLK_HZ - 1);
      adv    = tc && !ld;
      wrap_m = b.sec == 6'd59 && b.min == 6'd59;
      dw     = wrap_m && b.hour == 5'd23;
      ns     = b.sec == 6'd59 ? 6'd0 : b.sec + 6'd1;
      nm     = b.sec != 6'd59 ? b.min : b.min == 6'd59 ? 6'd0 : b.min + 6'd1;
      nh     = !wrap_m ? b.hour : dw ? 5'd0 : b.hour + 5'd1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre         <= '0;
         b.hour      <= '0;
         b.min       <= '0;
         b.sec       <= '0;
         b.timestamp <= '0;
         b.tick      <= 1'b0;
         b.day_wrap  <= 1'b0;
         b.alarm     <= 1'b0;
         b.set_err   <= 1'b0;
      end else begin
         b.tick     <= adv;
         b.day_wrap <= adv && dw;
         b.alarm    <= adv && b.alarm_en && nh == b.alarm_hour && nm == b.alarm_min && ns == b.alarm_sec;
         b.set_err  <= b.set_valid && !ok;
         // a valid load restarts the second so the next tick is a full period away
         if (ld) begin
            pre    <= '0;
            b.hour <= b.set_hour;
            b.min  <= b.set_min;
            b.sec  <= b.set_sec;
         end else if (b.run) begin
            pre <= tc ? '0 : pre + PW'(1);
            if (tc) begin
               b.hour      <= nh;
               b.min       <= nm;
               b.sec       <= ns;
               b.timestamp <= b.timestamp + TS_WIDTH'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_rtc_core.sv
// tb_rtc_core: randomized and directed checks of rtc_core against a seconds-of-day model.
`timescale 1ns/1ps
module tb_rtc_core;
   localparam int HZ = 4;
   localparam int TW = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int compared = 0;
   int mismatched = 0;
   rtc_core_if #(.TS_WIDTH(TW)) b();
   rtc_core #(.CLK_HZ(HZ), .TS_WIDTH(TW)) dut(.clk(clk), .rst_n(rst_n), .b(b));
   always #5 clk = ~clk;

   int tod, ts, pc;
   logic e_tick, e_dw, e_alarm, e_err;

   always @(posedge clk or negedge rst_n) begin : model
      int ok, tcm, nt;
      if (!rst_n) begin
         tod <= 0; ts <= 0; pc <= 0;
         e_tick <= 0; e_dw <= 0; e_alarm <= 0; e_err <= 0;
      end else begin
         ok  = b.set_valid && b.set_hour <= 23 && b.set_min <= 59 && b.set_sec <= 59;
         tcm = b.run && pc == HZ - 1;
         nt  = (tod + 1) % 86400;
         e_err   <= b.set_valid && !ok;
         e_tick  <= tcm && !ok;
         e_dw    <= tcm && !ok && tod == 86399;
         e_alarm <= tcm && !ok && b.alarm_en && nt == b.alarm_hour * 3600 + b.alarm_min * 60 + b.alarm_sec;
         if (ok) begin
            tod <= b.set_hour * 3600 + b.set_min * 60 + b.set_sec;
            pc  <= 0;
         end else if (tcm) begin
            tod <= nt;
            ts  <= (ts + 1) % (1 << TW);
            pc  <= 0;
         end else if (b.run) pc <= pc + 1;
      end
   end

   task automatic chk(input string n, input longint a, input longint e);
      compared++;
      if (a != e) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("hour", b.hour, tod / 3600);
      chk("min", b.min, (tod / 60) % 60);
      chk("sec", b.sec, tod % 60);
      chk("timestamp", b.timestamp, ts);
      chk("tick", b.tick, e_tick);
      chk("day_wrap", b.day_wrap, e_dw);
      chk("alarm", b.alarm, e_alarm);
      chk("set_err", b.set_err, e_err);
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input int h, input int m, input int s);
      b.set_hour = 5'(h); b.set_min = 6'(m); b.set_sec = 6'(s);
      b.set_valid = 1'b1;
      step();
      b.set_valid = 1'b0;
   endtask

   initial begin
      int t;
      b.run = 0; b.set_valid = 0; b.set_hour = 0; b.set_min = 0; b.set_sec = 0;
      b.alarm_en = 1; b.alarm_hour = 0; b.alarm_min = 0; b.alarm_sec = 3;
      step(3);
      chk("rst_sec", b.sec, 0);
      chk("rst_ts", b.timestamp, 0);
      chk("rst_tick", b.tick, 0);
      rst_n = 1; b.run = 1;
      step(3);
      chk("first_tick_early", b.tick, 0);
      step();
      chk("first_tick", b.tick, 1);
      chk("first_sec", b.sec, 1);
      chk("first_ts", b.timestamp, 1);
      step();
      chk("tick_one_cycle", b.tick, 0);
      step(7);
      chk("alarm_fire", b.alarm, 1);
      chk("alarm_sec", b.sec, 3);
      b.alarm_en = 0;
      load(0, 0, 2);
      step(4);
      chk("alarm_off_tick", b.tick, 1);
      chk("alarm_off", b.alarm, 0);
      b.alarm_en = 1;
      load(0, 0, 3);
      chk("alarm_on_load", b.alarm, 0);
      chk("load_sec", b.sec, 3);
      load(23, 59, 58);
      step(4);
      chk("roll_sec59", b.sec, 59);
      step(4);
      chk("roll_hour", b.hour, 0);
      chk("roll_sec", b.sec, 0);
      chk("roll_dw", b.day_wrap, 1);
      chk("roll_tick", b.tick, 1);
      step(3);
      load(12, 34, 56);
      chk("coll_tick", b.tick, 0);
      chk("coll_hour", b.hour, 12);
      chk("coll_sec", b.sec, 56);
      step(3);
      chk("coll_early", b.tick, 0);
      step();
      chk("coll_next", b.tick, 1);
      chk("coll_next_sec", b.sec, 57);
      load(24, 0, 0);
      chk("inv_err1", b.set_err, 1);
      chk("inv_sec", b.sec, 57);
      load(10, 60, 0);
      chk("inv_err2", b.set_err, 1);
      step();
      chk("inv_err_clr", b.set_err, 0);
      step();
      chk("inv_pre_kept", b.tick, 1);
      chk("inv_pre_sec", b.sec, 58);
      step(2);
      b.run = 0;
      step(10);
      chk("pause_tick", b.tick, 0);
      chk("pause_sec", b.sec, 58);
      b.run = 1;
      step();
      chk("resume_early", b.tick, 0);
      step();
      chk("resume_tick", b.tick, 1);
      chk("resume_sec", b.sec, 59);
      for (int i = 0; i < 3000; i++) begin
         b.run = ($urandom % 8) != 0;
         b.set_valid = ($urandom % 16) == 0;
         b.set_hour = 5'($urandom % 26);
         b.set_min = 6'($urandom % 62);
         b.set_sec = 6'($urandom % 62);
         if ($urandom % 32 == 0) begin
            b.alarm_en = $urandom % 4 != 0;
            t = (tod + $urandom_range(1, 3)) % 86400;
            b.alarm_hour = 5'(t / 3600); b.alarm_min = 6'((t / 60) % 60); b.alarm_sec = 6'(t % 60);
         end
         step();
      end
      b.set_valid = 0; b.run = 1;
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      chk("async_hour", b.hour, 0);
      chk("async_min", b.min, 0);
      chk("async_sec", b.sec, 0);
      chk("async_ts", b.timestamp, 0);
      step();
      rst_n = 1;
      step(16 * HZ);
      chk("wrap_ts", b.timestamp, 0);
      chk("wrap_sec", b.sec, 16);
      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/rtc_core.md
Name: rtc_core

Overview:
- Single-clock-domain real-time clock. Replaces derived-clock timekeeping with a parametrised prescaler that produces a 1 Hz clock-enable.
- Keeps hour/minute/second as incrementing counters, so no divide or modulo logic is needed. Also keeps a free-running uptime timestamp.
- Adds run/pause, time load and a one-shot alarm.
- Feeds the on-screen clock overlay and the capture timestamping path of the scope.

Parameters:
- CLK_HZ, 125_000_000, input clock frequency; prescaler period in cycles (>=2).
- TS_WIDTH, 32, width of the uptime timestamp counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- run  input  1  1 = time advances; 0 = prescaler and all counters hold
- set_valid  input  1  one-cycle request to load set_* into the time registers
- set_hour  input  5  load value, 0..23
- set_min  input  6  load value, 0..59
- set_sec  input  6  load value, 0..59
- alarm_en  input  1  enables alarm matching
- alarm_hour  input  5  alarm compare value
- alarm_min  input  6  alarm compare value
- alarm_sec  input  6  alarm compare value
- hour  output  5  current hour, 0..23
- min  output  6  current minute, 0..59
- sec  output  6  current second, 0..59
- timestamp  output  TS_WIDTH  seconds elapsed since reset
- tick  output  1  one-cycle pulse per elapsed second
- day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00
- alarm  output  1  one-cycle pulse when the time becomes equal to the alarm value
- set_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low. Assertion clears everything immediately; release is synchronous to clk.
- Reset values: prescaler 0, hour/min/sec 0, timestamp 0, tick/day_wrap/alarm/set_err 0. Reset mid-second discards the partial second.
- Prescaler: counts 0..CLK_HZ-1 only while run=1. On the edge where prescaler==CLK_HZ-1 and run=1:
  - prescaler -> 0 and tick <= 1 for exactly one cycle;
  - the time advances on the same edge, so tick and the new time are visible in the same cycle.
- Time advance:
  - sec+1. At 59, sec wraps to 0 and min increments.
  - min wraps at 59 and hour increments.
  - hour wraps at 23 -> 0 with day_wrap=1 in the tick cycle.
- timestamp increments on every tick. It wraps 2^TS_WIDTH-1 -> 0 silently.
- run=0: prescaler, time and timestamp hold. tick is never asserted. Resuming continues from the held prescaler value.
- Load (set_valid=1):
  - Valid only if hour<=23, min<=59 and sec<=59. On a valid load, all three registers load on that edge and the prescaler clears to 0, so the next tick comes a full CLK_HZ run-cycles later.
  - timestamp is never affected by a load.
  - An invalid load changes nothing and pulses set_err for one cycle.
- Simultaneous valid set_valid and prescaler terminal count: the load wins. No tick, no timestamp increment, no alarm, no day_wrap that cycle.
- Simultaneous invalid set_valid and terminal count: the normal tick proceeds and set_err pulses.
- Loads are accepted whether run is 0 or 1.
- Alarm:
  - Evaluated only on tick-driven advances. alarm=1 in the tick cycle when alarm_en=1 and the new hour/min/sec equal alarm_hour/min/sec.
  - Loading a time equal to the alarm does not fire.
  - Alarm compare values are sampled at the tick edge.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset/count, CLK_HZ=4: release rst_n with run=1 -> first tick on the 4th edge after release; sec 0->1 and timestamp 0->1 in the tick cycle; tick high for exactly 1 cycle every 4 cycles.
- Rollover: load 23:59:58, run 2 seconds -> 23:59:59, then 00:00:00 with day_wrap=1 and tick=1 in the same cycle; timestamp +2.
- Load/tick collision: assert a valid set_valid (12:34:56) on the terminal-count cycle -> time = 12:34:56, no tick, timestamp unchanged, next tick 4 cycles later gives 12:34:57.
- Invalid load: set 24:00:00, then 10:60:00 -> set_err pulses once each; time and prescaler unchanged.
- Alarm: alarm 00:00:03 with alarm_en=1 from reset -> alarm pulses exactly in the tick cycle where sec becomes 3. Repeat with alarm_en=0 -> no pulse. Load 00:00:03 directly -> no pulse.
- Pause and async reset: deassert run mid-second for 10 cycles -> no tick, values hold; resume and the tick arrives after the remaining count. Pull rst_n low between clock edges -> all outputs 0 immediately.
- Timestamp wrap: TS_WIDTH=4 -> after 16 ticks, timestamp returns to 0.
